// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction-fetch buffer.
//   - NOP_INST     : instruction word placed in a misaligned-fetch fault slot
//   - fetch_slot_t : one slot of the fetch queue {pc, inst, filled, fault}
//   - clog2()      : ceiling log2 for sizing pointers and counters
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        filled;
        logic        fault;
    } fetch_slot_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ifetch_buffer_if.sv
// ----------------------------------------------------------------------------
// ifetch_buffer_if
//   Bus bundle between the fetch buffer, instruction memory and decode.
//   imem request : imem_req_valid, imem_req_ready, imem_req_addr
//   imem response: imem_rsp_valid, imem_rsp_data (in order, never stalled)
//   decode       : dec_valid, dec_ready, dec_inst, dec_pc
//                  dec_fault only when FETCH_ALIGN_CHECK_EN is defined
//   modport master: the fetch buffer side; modport slave: imem/decode side.
// ----------------------------------------------------------------------------
interface ifetch_buffer_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        dec_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output dec_valid, dec_inst, dec_pc, dec_fault,
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  dec_valid, dec_inst, dec_pc, dec_fault,
        output dec_ready
    );
`else
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output dec_valid, dec_inst, dec_pc,
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  dec_valid, dec_inst, dec_pc,
        output dec_ready
    );
`endif

endinterface

// File: rtl/fetch_slot_array.sv
// ----------------------------------------------------------------------------
// fetch_slot_array
//   DEPTH-entry slot storage for the fetch queue.
//   Ports:
//     clk, rst_n                         clock, async active-low reset
//     flush                              clears every filled/fault flag
//     alloc_en/alloc_idx/alloc_pc        allocate a slot with its pc
//     alloc_fault                        allocate as an already-filled fault
//                                        slot carrying NOP_INST
//     fill_en/fill_idx/fill_inst         write the instruction, mark filled
//     rd_idx/rd_slot                     combinational head read port
// ----------------------------------------------------------------------------
module fetch_slot_array
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          alloc_en,
    input  logic [AW-1:0] alloc_idx,
    input  logic [31:0]   alloc_pc,
    input  logic          alloc_fault,
    input  logic          fill_en,
    input  logic [AW-1:0] fill_idx,
    input  logic [31:0]   fill_inst,
    input  logic [AW-1:0] rd_idx,
    output fetch_slot_t   rd_slot
);

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [DEPTH-1:0] fault_q;

    // Control flags carry the slot state and are reset/flushed.
    // NOTE: sequential state is written with non-blocking assignments so every
    // always_ff samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filled_q <= '0;
            fault_q  <= '0;
        end else if (flush) begin
            filled_q <= '0;
            fault_q  <= '0;
        end else begin
            if (alloc_en) begin
                filled_q[alloc_idx] <= alloc_fault;
                fault_q[alloc_idx]  <= alloc_fault;
            end
            if (fill_en) begin
                filled_q[fill_idx] <= 1'b1;
            end
        end
    end

    // NOTE: the pc/inst payload has no reset; it is only observed through a
    // slot whose filled flag is set, and the flags are reset above.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            pc_q[alloc_idx] <= alloc_pc;
            if (alloc_fault) begin
                inst_q[alloc_idx] <= NOP_INST;
            end
        end
        if (fill_en) begin
            inst_q[fill_idx] <= fill_inst;
        end
    end

    assign rd_slot = '{pc:     pc_q[rd_idx],
                       inst:   inst_q[rd_idx],
                       filled: filled_q[rd_idx],
                       fault:  fault_q[rd_idx]};

endmodule

// File: rtl/ifetch_buffer.sv
// ----------------------------------------------------------------------------
// ifetch_buffer
//   Fetch front end between the PC register and instruction memory. Issues a
//   request for fetch_pc whenever a slot and an outstanding-request credit are
//   free, pulses pc_advance on acceptance, collects in-order imem responses
//   into a DEPTH-slot queue and presents {pc, inst} to decode. A redirect
//   flushes the queue; responses still in flight are counted in drop_cnt and
//   discarded as they return.
//   Ports:
//     clk, rst_n    clock, async active-low reset
//     fetch_pc      current PC from the PC register
//     pc_advance    request accepted; PC register loads the next PC
//     redirect      flush pulse; PC register loads the target on the same edge
//     bus           ifetch_buffer_if.master (imem request/response, decode)
//   Build option: FETCH_ALIGN_CHECK_EN turns a misaligned fetch_pc into a
//   fault slot (inst = NOP_INST, dec_fault = 1) and stalls until redirect.
// ----------------------------------------------------------------------------
module ifetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       fetch_pc,
    output logic              pc_advance,
    input  logic              redirect,
    ifetch_buffer_if.master   bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t          DEPTH_C = cnt_t'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    ptr_t        alloc_ptr, fill_ptr, rd_ptr;
    cnt_t        used, inflight, drop_cnt;
    logic [CW:0] outstanding;
    logic        room, fetch_blocked, fault_alloc;
    logic        issue, alloc, keep_rsp, pop, dec_valid;
    fetch_slot_t head;

    // Every request that has left but not returned holds a credit, whether
    // its response will be kept (inflight) or thrown away (drop_cnt).
    assign outstanding = {1'b0, drop_cnt} + {1'b0, inflight};
    assign room        = (used < DEPTH_C) && (outstanding < DEPTH_W);

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned, fault_hold;

    assign misaligned    = (fetch_pc[1:0] != 2'b00);
    assign fetch_blocked = misaligned || fault_hold;
    // The fault slot waits for older requests to return so that fill order
    // stays equal to allocation order (fill_ptr == alloc_ptr here).
    assign fault_alloc   = !redirect && misaligned && !fault_hold &&
                           (used < DEPTH_C) && (inflight == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_hold <= 1'b0;
        end else if (redirect) begin
            fault_hold <= 1'b0;
        end else if (fault_alloc) begin
            fault_hold <= 1'b1;
        end
    end

    assign bus.dec_fault = dec_valid && head.fault;
`else
    logic fault_unused;

    assign fetch_blocked = 1'b0;
    assign fault_alloc   = 1'b0;
    assign fault_unused  = head.fault;
`endif

    // rst_n gates the request so nothing is offered while reset is held.
    assign bus.imem_req_valid = rst_n && !redirect && !fetch_blocked && room;
    assign bus.imem_req_addr  = {fetch_pc[31:2], 2'b00};
    assign issue              = bus.imem_req_valid && bus.imem_req_ready;
    assign pc_advance         = issue;
    assign alloc              = issue || fault_alloc;

    // A response in the redirect cycle is always stale.
    assign keep_rsp = bus.imem_rsp_valid && !redirect && (drop_cnt == '0);

    // used guards against a stale filled flag in a slot that has been popped
    // but not yet re-allocated.
    assign dec_valid     = head.filled && (used != '0);
    assign pop           = dec_valid && bus.dec_ready && !redirect;
    assign bus.dec_valid = dec_valid;
    assign bus.dec_inst  = dec_valid ? head.inst : '0;
    assign bus.dec_pc    = dec_valid ? head.pc   : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            used      <= '0;
            inflight  <= '0;
            drop_cnt  <= '0;
        end else if (redirect) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            used      <= '0;
            inflight  <= '0;
            drop_cnt  <= drop_cnt + inflight - cnt_t'(bus.imem_rsp_valid);
        end else begin
            if (alloc) begin
                alloc_ptr <= alloc_ptr + ptr_t'(1);
            end
            if (keep_rsp || fault_alloc) begin
                fill_ptr <= fill_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            used     <= used + cnt_t'(alloc) - cnt_t'(pop);
            inflight <= inflight + cnt_t'(issue) - cnt_t'(keep_rsp);
            if (bus.imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - cnt_t'(1);
            end
        end
    end

    fetch_slot_array #(
        .DEPTH (DEPTH)
    ) u_slots (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (redirect),
        .alloc_en    (alloc),
        .alloc_idx   (alloc_ptr),
        .alloc_pc    (fetch_pc),
        .alloc_fault (fault_alloc),
        .fill_en     (keep_rsp),
        .fill_idx    (fill_ptr),
        .fill_inst   (bus.imem_rsp_data),
        .rd_idx      (rd_ptr),
        .rd_slot     (head)
    );

endmodule
